reg_dump_collector: RTL



---
 rtl/reg_dump_collector.sv | 118 +++++++++++
 1 files changed

// File: rtl/reg_dump_collector.sv
// Watches the chip output bus for the end-of-program register dump and publishes
// a parallel snapshot of R0..R7 plus the frozen cycle count, with error/stability flags.
module reg_dump_collector #(
    parameter int CNT_W      = 6,
    parameter int REG_W      = 3,
    parameter int DUMP_CNT_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CNT_W+3+REG_W-1:0] chip_out,
    output logic                     dump_valid,
    output logic                     dump_error,
    output logic [CNT_W-1:0]         final_cycles,
    output logic [8*REG_W-1:0]       regs_flat,
    output logic [DUMP_CNT_W-1:0]    dump_count,
    output logic                     stable,
    output logic                     capturing
);

    typedef enum logic [1:0] {IDLE, CAPTURE, PUBLISH} state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   prev_cnt;
    logic [CNT_W-1:0]   frozen;
    logic [2:0]         idx;
    logic [2:0]         expected;
    logic [REG_W-1:0]   dat;
    logic [8*REG_W-1:0] shadow;
    logic               prev_valid;
    logic               dump_start;
    logic               good_sample;

    assign cnt = chip_out[CNT_W+3+REG_W-1 -: CNT_W];
    assign idx = chip_out[REG_W+2 : REG_W];
    assign dat = chip_out[REG_W-1:0];

    // The chip count only repeats once frozen, so a repeated count with idx 0 marks a dump.
    assign dump_start  = prev_valid && (cnt == prev_cnt) && (idx == 3'd0);
    assign good_sample = (cnt == frozen) && (idx == expected);
    assign capturing   = (state == CAPTURE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (dump_start) next_state = CAPTURE;
            CAPTURE: begin
                if (!good_sample) begin
                    next_state = IDLE;
                end else if (expected == 3'd7) begin
                    next_state = PUBLISH;
                end
            end
            PUBLISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_cnt     <= '0;
            prev_valid   <= 1'b0;
            frozen       <= '0;
            expected     <= '0;
            shadow       <= '0;
            dump_valid   <= 1'b0;
            dump_error   <= 1'b0;
            final_cycles <= '0;
            regs_flat    <= '0;
            dump_count   <= '0;
            stable       <= 1'b0;
        end else begin
            prev_cnt   <= cnt;
            prev_valid <= 1'b1;
            dump_valid <= 1'b0;
            dump_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        shadow[REG_W-1:0] <= dat;
                        frozen            <= cnt;
                        expected          <= 3'd1;
                    end
                end
                CAPTURE: begin
                    if (good_sample) begin
                        shadow[expected*REG_W +: REG_W] <= dat;
                        if (expected != 3'd7) expected <= expected + 3'd1;
                    end else begin
                        // Abort: the offending sample is not re-examined as a dump start.
                        dump_error <= 1'b1;
                        shadow     <= '0;
                        expected   <= '0;
                    end
                end
                PUBLISH: begin
                    regs_flat    <= shadow;
                    final_cycles <= frozen;
                    dump_valid   <= 1'b1;
                    if (dump_count != '1) dump_count <= dump_count + 1'b1;
                    stable <= (dump_count != '0) && (shadow == regs_flat) && (frozen == final_cycles);
                    expected <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
